platform_scroller: RTL and testbench

PLATFORM_SCROLLER -- requirements
Module: platform_scroller

---
 rtl/doodle_pkg.sv | 16 +
 rtl/plat_lfsr.sv | 28 ++
 rtl/platform_scroller.sv | 177 +++++++++++++++++
 tb/tb_platform_scroller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared types and default playfield geometry for the Doodle platform logic.
package doodle_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      WAIT_FRAME,
      SCROLL,
      DONE
   } state_t;

   localparam int DOODLE_SCREEN_W = 640;
   localparam int DOODLE_SCREEN_H = 480;
   localparam int DOODLE_PLAT_W   = 64;

endpackage

// File: rtl/plat_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (x^10+x^7+1) folded into [0, RANGE).
// The fold is a single subtraction, so 2*RANGE must cover the 10-bit space.
module plat_lfsr #(
   parameter int         COORD_W = 10,
   parameter logic [9:0] SEED    = 10'h2A5,
   parameter int         RANGE   = 576
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [COORD_W-1:0] rand_x
);

   localparam logic [9:0] RANGE_L = 10'(RANGE);

   logic [9:0] lfsr;

   // advance one step every clock; seed must be nonzero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= SEED;
      else        lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
   end

   // fold the raw state into the legal x range
   always_comb begin
      rand_x = COORD_W'((lfsr < RANGE_L) ? lfsr : (lfsr - RANGE_L));
   end

endmodule

// File: rtl/platform_scroller.sv
// Platform layout builder and per-frame vertical scroller. One slot is
// touched per clock in INIT and SCROLL; frames arriving mid-pass queue once.
module platform_scroller
   import doodle_pkg::*;
#(
   parameter int         NUM_PLAT    = 15,
   parameter int         COORD_W     = 10,
   parameter int         SCREEN_W    = DOODLE_SCREEN_W,
   parameter int         SCREEN_H    = DOODLE_SCREEN_H,
   parameter int         PLAT_W      = DOODLE_PLAT_W,
   parameter int         SCROLL_LINE = 200,
   parameter int         MAX_DY      = 15,
   parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
   input  logic                              Clk,
   input  logic                              Reset_n,
   input  logic                              frame_clk,
   input  logic                              start,
   input  logic [COORD_W-1:0]                doodle_y,
   input  logic signed [COORD_W-1:0]         doodle_vy,
   output logic [NUM_PLAT-1:0][COORD_W-1:0]  plat_x,
   output logic [NUM_PLAT-1:0][COORD_W-1:0]  plat_y,
   output logic [NUM_PLAT-1:0]               plat_valid,
   output logic                              busy,
   output logic                              refresh_en,
   output logic [7:0]                        displacement,
   output logic [15:0]                       score,
   output logic                              overrun
);

   localparam int                IDX_W   = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
   localparam logic [IDX_W-1:0]  LAST    = IDX_W'(NUM_PLAT - 1);
   localparam int                ROW_GAP = SCREEN_H / NUM_PLAT;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [2:0]           fsync;
   logic                 frame_evt;
   logic                 pending;
   logic [COORD_W-1:0]   dy, dy_calc;
   logic signed [COORD_W:0] vy_neg;
   logic [COORD_W:0]     sum;
   logic                 wrap;
   logic [COORD_W-1:0]   rand_x;

   plat_lfsr #(
      .COORD_W (COORD_W),
      .SEED    (LFSR_SEED),
      .RANGE   (SCREEN_W - PLAT_W)
   ) u_lfsr (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .rand_x (rand_x)
   );

   // two-flop synchronizer plus a history flop for rising-edge detect
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) fsync <= '0;
      else          fsync <= {fsync[1:0], frame_clk};
   end
   assign frame_evt = fsync[1] & ~fsync[2];

   // scroll amount: only upward motion above the scroll line moves the field
   always_comb begin
      vy_neg  = -$signed({doodle_vy[COORD_W-1], doodle_vy});
      dy_calc = '0;
      if (doodle_y < COORD_W'(SCROLL_LINE) && doodle_vy[COORD_W-1]) begin
         if (vy_neg > $signed((COORD_W+1)'(MAX_DY))) dy_calc = COORD_W'(MAX_DY);
         else                                        dy_calc = vy_neg[COORD_W-1:0];
      end
      sum  = {1'b0, plat_y[idx]} + {1'b0, dy};
      wrap = (sum >= (COORD_W+1)'(SCREEN_H));
   end

   // state and slot-index register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // next-state logic; start overrides everything
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (start) begin
         state_nxt = INIT;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: ;
            INIT: begin
               if (idx == LAST) begin
                  state_nxt = WAIT_FRAME;
                  idx_nxt   = '0;
               end else idx_nxt = idx + 1'b1;
            end
            WAIT_FRAME: begin
               if (frame_evt || pending) begin
                  state_nxt = SCROLL;
                  idx_nxt   = '0;
               end
            end
            SCROLL: begin
               if (idx == LAST) begin
                  state_nxt = DONE;
                  idx_nxt   = '0;
               end else idx_nxt = idx + 1'b1;
            end
            DONE:    state_nxt = WAIT_FRAME;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy       = (state == INIT) || (state == SCROLL) || (state == DONE);
   assign refresh_en = (state == DONE) && (dy != '0);

   // slot table, frame queueing and scoreboard
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         plat_x       <= '0;
         plat_y       <= '0;
         plat_valid   <= '0;
         score        <= '0;
         displacement <= '0;
         dy           <= '0;
         pending      <= 1'b0;
         overrun      <= 1'b0;
      end else if (start) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               plat_y[idx]     <= COORD_W'(SCREEN_H - 16 - int'(idx) * ROW_GAP);
               plat_x[idx]     <= rand_x;
               plat_valid[idx] <= 1'b1;
               if (idx == LAST) score <= '0;
            end
            WAIT_FRAME: begin
               if (frame_evt || pending) begin
                  dy      <= dy_calc;
                  // a fresh edge arriving as the queued one is consumed stays queued
                  pending <= pending & frame_evt;
               end
            end
            SCROLL: begin
               if (wrap) begin
                  plat_y[idx] <= COORD_W'(sum - (COORD_W+1)'(SCREEN_H));
                  plat_x[idx] <= rand_x;
                  if (score != 16'hFFFF) score <= score + 16'd1;
               end else begin
                  plat_y[idx] <= sum[COORD_W-1:0];
               end
               if (frame_evt) begin
                  if (pending) overrun <= 1'b1;
                  else         pending <= 1'b1;
               end
            end
            DONE: begin
               displacement <= dy[7:0];
               if (frame_evt) begin
                  if (pending) overrun <= 1'b1;
                  else         pending <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_platform_scroller.sv
// Directed bench for platform_scroller: table of scroll vectors checked
// against a slot-position model, plus hand sequences for queueing and reset.
module tb_platform_scroller;

   localparam int NP = 15;
   localparam int CW = 10;

   logic                   Clk = 1'b0;
   logic                   Reset_n = 1'b0;
   logic                   frame_clk = 1'b0;
   logic                   start = 1'b0;
   logic [CW-1:0]          doodle_y = '0;
   logic signed [CW-1:0]   doodle_vy = '0;
   logic [NP-1:0][CW-1:0]  plat_x, plat_y;
   logic [NP-1:0]          plat_valid;
   logic                   busy, refresh_en, overrun;
   logic [7:0]             displacement;
   logic [15:0]            score;

   platform_scroller dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
      .doodle_y(doodle_y), .doodle_vy(doodle_vy),
      .plat_x(plat_x), .plat_y(plat_y), .plat_valid(plat_valid),
      .busy(busy), .refresh_en(refresh_en), .displacement(displacement),
      .score(score), .overrun(overrun)
   );

   always #10 Clk = ~Clk;

   int checks = 0;
   int failures = 0;
   int refresh_total = 0;
   int exp_y[NP];
   int exp_score = 0;

   always @(negedge Clk) if (refresh_en) refresh_total <= refresh_total + 1;

   typedef struct {
      int y;
      int vy;
      int dy;
      int pulses;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_layout(input string tag);
      int bad_y, bad_x;
      bad_y = 0;
      bad_x = 0;
      for (int i = 0; i < NP; i++) begin
         if (int'(plat_y[i]) != exp_y[i]) bad_y++;
         if (int'(plat_x[i]) >= 576) bad_x++;
      end
      check({tag, "_y_mismatch_slots"}, bad_y, 0);
      check({tag, "_x_out_of_range"}, bad_x, 0);
      check({tag, "_score"}, int'(score), exp_score);
   endtask

   task automatic do_start(input string tag);
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      check({tag, "_init_busy_cycles"}, n, NP);
      for (int i = 0; i < NP; i++) exp_y[i] = 464 - 32 * i;
      exp_score = 0;
      check({tag, "_valid"}, int'(plat_valid), 32'h7FFF);
      check({tag, "_overrun"}, int'(overrun), 0);
      check_layout(tag);
   endtask

   task automatic apply_model(input int dy);
      for (int i = 0; i < NP; i++) begin
         exp_y[i] = exp_y[i] + dy;
         if (exp_y[i] >= 480) begin
            exp_y[i] = exp_y[i] - 480;
            exp_score++;
         end
      end
   endtask

   // raise a frame edge, wait for the pass to start and return its length
   task automatic run_frame(output int len);
      int n;
      frame_clk = 1'b1;
      n = 0;
      while (!busy && n < 20) begin
         n++;
         tick();
      end
      frame_clk = 1'b0;
      len = 0;
      while (busy && len < 40) begin
         len++;
         tick();
      end
      repeat (3) tick();
   endtask

   vec_t vecs[10];

   initial begin
      int len, r0, nbusy, distinct;
      vecs[0] = '{150,   -6,  6, 1};
      vecs[1] = '{150,  -12, 12, 1};
      vecs[2] = '{150,  -40, 15, 1};
      vecs[3] = '{300,   -6,  0, 0};
      vecs[4] = '{150,    5,  0, 0};
      vecs[5] = '{199,  -15, 15, 1};
      vecs[6] = '{200,   -3,  0, 0};
      vecs[7] = '{150,  -16, 15, 1};
      vecs[8] = '{0,     -1,  1, 1};
      vecs[9] = '{100, -512, 15, 1};

      // reset state
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(plat_valid), 0);
      check("rst_plat_y_nonzero", int'(plat_y != '0), 0);
      check("rst_plat_x_nonzero", int'(plat_x != '0), 0);
      check("rst_score", int'(score), 0);
      check("rst_disp", int'(displacement), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_refresh", int'(refresh_en), 0);
      Reset_n = 1'b1;
      tick();

      do_start("boot");
      distinct = 0;
      for (int i = 1; i < NP; i++) if (plat_x[i] != plat_x[0]) distinct++;
      check("boot_x_not_constant", int'(distinct > 0), 1);
      check("boot_y0", int'(plat_y[0]), 464);
      check("boot_y14", int'(plat_y[14]), 16);

      // table-driven scroll passes
      for (int v = 0; v < 10; v++) begin
         doodle_y  = CW'(vecs[v].y);
         doodle_vy = CW'(vecs[v].vy);
         r0 = refresh_total;
         run_frame(len);
         check($sformatf("v%0d_pass_len", v), len, NP + 1);
         check($sformatf("v%0d_disp", v), int'(displacement), vecs[v].dy);
         check($sformatf("v%0d_refresh", v), refresh_total - r0, vecs[v].pulses);
         apply_model(vecs[v].dy);
         check_layout($sformatf("v%0d", v));
         if (v == 1) check("wrap_slot0_y", int'(plat_y[0]), 2);
      end

      // three edges within one pass: one extra pass, overrun latches
      doodle_y  = 10'd150;
      doodle_vy = -10'sd3;
      r0 = refresh_total;
      frame_clk = 1'b1;
      nbusy = 0;
      while (!busy && nbusy < 20) begin
         nbusy++;
         tick();
      end
      nbusy = 0;
      for (int k = 0; k < 70; k++) begin
         frame_clk = ((k >= 4 && k < 7) || (k >= 10 && k < 13)) ? 1'b1 : 1'b0;
         if (busy) nbusy++;
         tick();
      end
      check("ovr_busy_cycles", nbusy, 2 * (NP + 1));
      check("ovr_refresh", refresh_total - r0, 2);
      check("ovr_flag", int'(overrun), 1);
      apply_model(3);
      apply_model(3);
      check_layout("ovr");
      repeat (10) tick();
      check("ovr_flag_sticky", int'(overrun), 1);
      do_start("restart");

      // start aborts a pass in flight
      frame_clk = 1'b1;
      nbusy = 0;
      while (!busy && nbusy < 20) begin
         nbusy++;
         tick();
      end
      frame_clk = 1'b0;
      repeat (5) tick();
      do_start("abort");

      // asynchronous reset at slot 7 of a pass
      repeat (3) tick();
      frame_clk = 1'b1;
      nbusy = 0;
      while (!busy && nbusy < 20) begin
         nbusy++;
         tick();
      end
      frame_clk = 1'b0;
      repeat (7) tick();
      #3;
      Reset_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(plat_valid), 0);
      check("mid_rst_plat_y_nonzero", int'(plat_y != '0), 0);
      check("mid_rst_plat_x_nonzero", int'(plat_x != '0), 0);
      check("mid_rst_score", int'(score), 0);
      check("mid_rst_disp", int'(displacement), 0);
      check("mid_rst_refresh", int'(refresh_en), 0);
      repeat (2) tick();
      Reset_n = 1'b1;
      repeat (2) tick();

      // frame edge in IDLE does nothing
      nbusy = 0;
      for (int k = 0; k < 15; k++) begin
         frame_clk = (k < 4) ? 1'b1 : 1'b0;
         if (busy) nbusy++;
         tick();
      end
      check("idle_frame_ignored", nbusy, 0);
      do_start("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
